// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin scheduler that shares one combinational Alu
// between two requesters over valid/ready request and response handshakes.
// Optional feature macro: ALU_ARB_STATS_EN adds saturating per-requester
// grant counters (grant_cnt0/grant_cnt1). The default build omits them.

// Combinational ALU shared by both requesters.
module Alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             coutfin,
    output logic             z
);

    logic [WIDTH:0] wideResult;

    // Opcode decode; coutfin is the carry (add) or borrow (sub) out of the MSB
    always_comb begin
        wideResult = '0;
        ALU_Out    = '0;
        coutfin    = 1'b0;
        case (ALU_Sel)
            4'b0000: ALU_Out = A & B;
            4'b0001: ALU_Out = A | B;
            4'b0010: begin
                wideResult = {1'b0, A} + {1'b0, B};
                ALU_Out    = wideResult[WIDTH-1:0];
                coutfin    = wideResult[WIDTH];
            end
            4'b0110: begin
                wideResult = {1'b0, A} - {1'b0, B};
                ALU_Out    = wideResult[WIDTH-1:0];
                coutfin    = wideResult[WIDTH];
            end
            4'b0111: ALU_Out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1100: ALU_Out = ~(A | B);
            4'b1101: ALU_Out = A ^ B;
            default: ALU_Out = '0;
        endcase
    end

    assign z = (ALU_Out == '0);

endmodule

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [3:0]       req_sel0,
    input  logic [3:0]       req_sel1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_z
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [3:0]       opSel_q, opSel_d;
    logic [WIDTH-1:0] rspData_q, rspData_d;
    logic             rspCout_q, rspCout_d;
    logic             rspZ_q, rspZ_d;

    logic             grantVld;
    logic             grantIdx;
    logic [WIDTH-1:0] aluOut;
    logic             aluCout;
    logic             aluZ;

    Alu #(.WIDTH(WIDTH)) uAlu (
        .A       (opA_q),
        .B       (opB_q),
        .ALU_Sel (opSel_q),
        .ALU_Out (aluOut),
        .coutfin (aluCout),
        .z       (aluZ)
    );

    // On a tie the requester that was not served last wins
    always_comb begin
        grantVld = (state_q == IDLE) && (req_valid != 2'b00);
        grantIdx = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    end

    // Handshake outputs; ready is held low while reset is asserted
    always_comb begin
        req_ready = 2'b00;
        if (grantVld && rst_n) begin
            req_ready = grantIdx ? 2'b10 : 2'b01;
        end
        rsp_valid = 2'b00;
        if (state_q == RESP) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign rsp_data = rspData_q;
    assign rsp_cout = rspCout_q;
    assign rsp_z    = rspZ_q;

    // FSM: latch operands on grant, capture ALU result after one EXEC cycle
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        opSel_d   = opSel_q;
        rspData_d = rspData_q;
        rspCout_d = rspCout_q;
        rspZ_d    = rspZ_q;
        case (state_q)
            IDLE: begin
                if (grantVld) begin
                    owner_d = grantIdx;
                    last_d  = grantIdx;
                    opA_d   = grantIdx ? req_a1 : req_a0;
                    opB_d   = grantIdx ? req_b1 : req_b0;
                    opSel_d = grantIdx ? req_sel1 : req_sel0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rspData_d = aluOut;
                rspCout_d = aluCout;
                rspZ_d    = aluZ;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            opSel_q   <= '0;
            rspData_q <= '0;
            rspCout_q <= 1'b0;
            rspZ_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            opSel_q   <= opSel_d;
            rspData_q <= rspData_d;
            rspCout_q <= rspCout_d;
            rspZ_q    <= rspZ_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Saturating count of accepted grants per requester
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (grantVld) begin
            if (!grantIdx && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
            if (grantIdx && (cnt1_q != '1))  cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter (reset, add, zero flag,
// back-pressure, fairness, mid-operation reset). Counter checks are active
// only when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [3:0]  req_sel0, req_sel1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_cout;
    logic        rsp_z;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    int          expCnt0, expCnt1;
`endif

    int checks;
    int errors;

    alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .req_sel0  (req_sel0),
        .req_sel1  (req_sel1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .rsp_z     (rsp_z)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rready);
        req_valid = valid;
        rsp_ready = rready;
    endtask

    task automatic checkCounters();
`ifdef ALU_ARB_STATS_EN
        checkOutput("grant_cnt0", 32'(grant_cnt0), 32'(expCnt0));
        checkOutput("grant_cnt1", 32'(grant_cnt1), 32'(expCnt1));
`endif
    endtask

    logic [31:0] expData [2];
    logic [1:0]  oneHot;
    int          g;

    initial begin
        checks = 0;
        errors = 0;
`ifdef ALU_ARB_STATS_EN
        expCnt0 = 0;
        expCnt1 = 0;
`endif
        rst_n     = 1'b0;
        req_a0    = 32'hABCD_EFFF;
        req_b0    = 32'h1234_5678;
        req_sel0  = 4'b0010;
        req_a1    = 32'h0000_0005;
        req_b1    = 32'h0000_0005;
        req_sel1  = 4'b0110;
        applyStimulus(2'b11, 2'b00);

        // Reset held two cycles with both requesters pending
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("reset req_ready", 32'(req_ready), 32'h0);
            checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
            checkOutput("reset rsp_data", rsp_data, 32'h0);
        end
        checkCounters();
        rst_n = 1'b1;
        #1;
        checkOutput("first tie grant", 32'(req_ready), 32'h1);

        // Single add on requester 0, then back-pressure
        tick();
`ifdef ALU_ARB_STATS_EN
        expCnt0++;
`endif
        checkOutput("exec req_ready", 32'(req_ready), 32'h0);
        checkOutput("exec rsp_valid", 32'(rsp_valid), 32'h0);
        applyStimulus(2'b10, 2'b00);
        tick();
        checkOutput("add rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("add rsp_data", rsp_data, 32'hBE02_4677);
        checkOutput("add rsp_cout", 32'(rsp_cout), 32'h0);
        checkOutput("add rsp_z", 32'(rsp_z), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("bp rsp_data", rsp_data, 32'hBE02_4677);
            checkOutput("bp req_ready", 32'(req_ready), 32'h0);
        end
        applyStimulus(2'b10, 2'b01);
        tick();
        checkOutput("bp release grant", 32'(req_ready), 32'h2);

        // Zero-flag subtract on requester 1
        applyStimulus(2'b10, 2'b11);
        tick();
`ifdef ALU_ARB_STATS_EN
        expCnt1++;
`endif
        applyStimulus(2'b00, 2'b11);
        tick();
        checkOutput("sub rsp_valid", 32'(rsp_valid), 32'h2);
        checkOutput("sub rsp_data", rsp_data, 32'h0);
        checkOutput("sub rsp_z", 32'(rsp_z), 32'h1);
        checkOutput("sub rsp_cout", 32'(rsp_cout), 32'h0);
        tick();
        checkOutput("idle no req", 32'(req_ready), 32'h0);
        checkOutput("idle rsp_valid", 32'(rsp_valid), 32'h0);
        checkCounters();

        // Fairness: both pending, last grant was requester 1
        req_a0 = 32'h0000_0001; req_b0 = 32'h0000_0002; req_sel0 = 4'b0010;
        req_a1 = 32'h0000_000A; req_b1 = 32'h0000_0003; req_sel1 = 4'b0110;
        expData[0] = 32'h0000_0003;
        expData[1] = 32'h0000_0007;
        applyStimulus(2'b11, 2'b11);
        #1;
        for (int op = 0; op < 4; op++) begin
            g = op % 2;
            oneHot = (g == 1) ? 2'b10 : 2'b01;
            checkOutput("fair grant", 32'(req_ready), 32'(oneHot));
            tick();
`ifdef ALU_ARB_STATS_EN
            if (g == 0) expCnt0++; else expCnt1++;
`endif
            checkOutput("fair exec ready", 32'(req_ready), 32'h0);
            tick();
            checkOutput("fair rsp_valid", 32'(rsp_valid), 32'(oneHot));
            checkOutput("fair rsp_data", rsp_data, expData[g]);
            tick();
        end
        checkCounters();

        // Mid-operation reset: grant req0, reset during EXEC
        checkOutput("pre-reset grant", 32'(req_ready), 32'h1);
        tick();
        rst_n = 1'b0;
        applyStimulus(2'b00, 2'b11);
        tick();
        checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("midrst rsp_data", rsp_data, 32'h0);
        rst_n = 1'b1;
`ifdef ALU_ARB_STATS_EN
        expCnt0 = 0;
        expCnt1 = 0;
`endif
        checkCounters();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("no stale rsp", 32'(rsp_valid), 32'h0);
        end
        applyStimulus(2'b11, 2'b11);
        #1;
        checkOutput("post-reset tie grant", 32'(req_ready), 32'h1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin scheduler that shares the single 32-bit `Alu` instance between two requesters. Each requester presents operands and an `ALU_Sel` opcode over a valid/ready handshake. The block then drives the shared ALU from registered operands and returns `ALU_Out`/`coutfin`/`z` over a per-requester response handshake. It sits between the core's execute-side requesters and the combinational `Alu`, which it instantiates.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must match `Alu`.
- `CNT_W`, 16: width of grant counters (only with `ALU_ARB_STATS_EN`).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  2  bit i: requester i has an operation pending.
- `req_ready`  out  2  bit i: requester i's operation accepted this cycle.
- `req_a0`, `req_a1`  in  WIDTH  operand A per requester.
- `req_b0`, `req_b1`  in  WIDTH  operand B per requester.
- `req_sel0`, `req_sel1`  in  4  ALU_Sel per requester.
- `rsp_valid`  out  2  bit i: result for requester i is available.
- `rsp_ready`  in  2  bit i: requester i takes its result.
- `rsp_data`  out  WIDTH  registered ALU_Out.
- `rsp_cout`  out  1  registered coutfin.
- `rsp_z`  out  1  registered z.
- `grant_cnt0`, `grant_cnt1`  out  CNT_W  accepted-op counters (only with `ALU_ARB_STATS_EN`).

## Operation
- FSM states: IDLE, EXEC, RESP.
- Round-robin pointer `last` (1 bit) records the last granted requester.
- **IDLE**:
  - If exactly one `req_valid` bit is set, grant that requester.
  - If both are set, grant `~last`.
  - Grant means:
    - `req_ready[g]` is asserted combinationally in the same cycle.
    - That requester's A/B/sel are latched into the ALU operand registers.
    - `owner<=g`, `last<=g`, next state EXEC.
  - If no request is valid, stay in IDLE and hold `req_ready=0`.
- **EXEC**:
  - The ALU sees the stable registered operands for one full cycle.
  - At the clock edge, `ALU_Out`, `coutfin` and `z` are captured into `rsp_data`, `rsp_cout` and `rsp_z`.
  - Next state RESP.
- **RESP**:
  - `rsp_valid[owner]=1`; the other bit is 0.
  - Response registers are held stable.
  - When `rsp_ready[owner]=1`, go to IDLE.
  - `rsp_ready` on the non-owner bit is ignored.
- `req_ready` is 0 in EXEC and RESP. A requester's valid and its operands must be held until it sees ready.
- ALU result semantics and width rules are `Alu`'s; the arbiter passes them through unmodified.

## Timing
- Reset values (any state, `rst_n` sampled low at a clock edge):
  - state=IDLE, `last=1` (so requester 0 wins the first tie).
  - `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_cout=0`, `rsp_z=0`.
  - Operand registers 0; grant counters 0.
- Latency: request accepted in cycle N (IDLE, valid&ready). `rsp_valid` is high from cycle N+2.
- Peak throughput: one operation per 3 cycles when `rsp_ready` is tied high.
- With `rsp_ready` low, the block stays in RESP indefinitely. No new grant occurs and operands of waiting requesters are not sampled.
- Reset during EXEC or RESP: the in-flight operation is discarded and its response is never presented.
- A requester that keeps `req_valid` high through its own response re-arbitrates in the IDLE cycle after RESP. On a tie with the other requester it loses.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - `grant_cnt0`/`grant_cnt1` exist; counter i increments by 1 on each accepted grant to requester i.
  - Counters saturate at 2^CNT_W−1 (no wrap) and clear on reset.
- `ALU_ARB_STATS_EN` not defined: the counter ports and logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles with both `req_valid=1` -> `req_ready=0`, `rsp_valid=0`, `rsp_data=0` throughout. The first grant after release goes to requester 0.
- **Single add:** req0 A=0xABCDEFFF, B=0x12345678, sel=4'b0010, `rsp_ready[0]=1` -> `req_ready=2'b01` at cycle N. `rsp_valid=2'b01` at N+2 with `rsp_data=0xBE024677`, `rsp_cout=0`, `rsp_z=0`.
- **Zero flag:** req1 A=0x00000005, B=0x00000005, subtract opcode -> `rsp_valid=2'b10`, `rsp_data=0`, `rsp_z=1`.
- **Fairness:** both valid continuously, `rsp_ready=2'b11` -> grants alternate 0,1,0,1 with `req_ready` pulses spaced 3 cycles apart. With stats enabled, `grant_cnt0=grant_cnt1=2` after 4 operations.
- **Back-pressure:** `rsp_ready[0]=0` for 5 cycles -> `rsp_valid[0]` and `rsp_data` stay stable and req1 gets no grant. One cycle after `rsp_ready[0]=1`, req1 is granted.
- **Mid-operation reset:** assert `rst_n=0` during EXEC -> next cycle IDLE with `rsp_valid=0`, and no stale response appears after release.
